// File: rtl/alu_operand_sequencer.sv
// Debounces load1/load2/equal buttons, captures operands and opcode, and strobes start to the ALU.
// Press-to-update is DEBOUNCE_CYCLES+2 edges; op_sel-to-op in DONE is 3 edges; no backpressure from the ALU.
module alu_operand_sequencer #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] number,
   input  logic         load1,
   input  logic         load2,
   input  logic         equal,
   input  logic         mux1,
   input  logic         mux2,
   input  logic         mux3,
   input  logic         mux4,
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic [3:0]   op,
   output logic         start,
   output logic [1:0]   state
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] WAIT_A  = 2'b00;
   localparam logic [1:0] WAIT_B  = 2'b01;
   localparam logic [1:0] WAIT_EQ = 2'b10;
   localparam logic [1:0] DONE    = 2'b11;

   // Bit 0 = load1, bit 1 = load2, bit 2 = equal; lower index wins on collision.
   logic [2:0]    btn_raw;
   logic [2:0]    bsync1_q, bsync2_q;
   logic [2:0]    deb_q, deb_d;
   logic [2:0]    press_q, press_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];

   logic [3:0]    opsync1_q, opsync2_q;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic [3:0]    op_q, op_d;
   logic          start_q, start_d;
   logic          pend_q, pend_d;
   logic [1:0]    state_q, state_d;
   logic          ld1, ld2, eq, want_start, stay_done;

   assign btn_raw = {equal, load2, load1};

   always_comb begin
      deb_d   = deb_q;
      press_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (bsync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i]   = bsync2_q[i];
               press_d[i] = deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign ld1 = press_q[0];
   assign ld2 = press_q[1] & ~press_q[0];
   assign eq  = press_q[2] & ~press_q[1] & ~press_q[0];

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      want_start = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (ld1) begin
               a_d     = number;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (ld1) begin
               a_d = number;
            end else if (ld2) begin
               b_d     = number;
               state_d = WAIT_EQ;
            end
         end
         WAIT_EQ: begin
            if (ld1) begin
               a_d = number;
            end else if (ld2) begin
               b_d = number;
            end else if (eq) begin
               op_d       = opsync2_q;
               want_start = 1'b1;
               state_d    = DONE;
            end
         end
         default: begin
            if (ld1) begin
               a_d     = number;
               state_d = WAIT_B;
            end else begin
               if (ld2) begin
                  b_d        = number;
                  want_start = 1'b1;
               end else if (eq) begin
                  want_start = 1'b1;
               end
               // Hold off op tracking while start is high so op and start stay aligned.
               if ((opsync2_q != op_q) && !start_q) begin
                  op_d       = opsync2_q;
                  want_start = 1'b1;
               end
            end
         end
      endcase
   end

   // A request landing right behind a strobe is deferred a cycle rather than merged.
   assign stay_done = (state_d == DONE);
   assign start_d   = (want_start | pend_q) & ~start_q & stay_done;
   assign pend_d    = (want_start | pend_q) &  start_q & stay_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bsync1_q  <= 3'b111;
         bsync2_q  <= 3'b111;
         deb_q     <= 3'b111;
         press_q   <= 3'b000;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         opsync1_q <= 4'b0000;
         opsync2_q <= 4'b0000;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 4'b0000;
         start_q   <= 1'b0;
         pend_q    <= 1'b0;
         state_q   <= WAIT_A;
      end else begin
         bsync1_q  <= btn_raw;
         bsync2_q  <= bsync1_q;
         deb_q     <= deb_d;
         press_q   <= press_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
         opsync1_q <= {mux1, mux2, mux3, mux4};
         opsync2_q <= opsync1_q;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         start_q   <= start_d;
         pend_q    <= pend_d;
         state_q   <= state_d;
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign op    = op_q;
   assign start = start_q;
   assign state = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES = 4.
module tb_alu_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] number = 4'b0000;
   logic       load1 = 1'b1, load2 = 1'b1, equal = 1'b1;
   logic       mux1 = 1'b0, mux2 = 1'b0, mux3 = 1'b0, mux4 = 1'b0;
   logic [3:0] a, b, op;
   logic       start;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;
   int start_cnt = 0;
   int consec_cnt = 0;
   logic prev_start = 1'b0;

   alu_operand_sequencer #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .number(number),
      .load1(load1), .load2(load2), .equal(equal),
      .mux1(mux1), .mux2(mux2), .mux3(mux3), .mux4(mux4),
      .a(a), .b(b), .op(op), .start(start), .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start === 1'b1) start_cnt++;
      if (start === 1'b1 && prev_start === 1'b1) consec_cnt++;
      prev_start = start;
   end

   // which: 1 = load1, 2 = load2, 3 = equal
   task automatic press(input int which, input int hold);
      @(negedge clk);
      case (which)
         1: load1 = 1'b0;
         2: load2 = 1'b0;
         default: equal = 1'b0;
      endcase
      repeat (hold) @(negedge clk);
      load1 = 1'b1; load2 = 1'b1; equal = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; load1 = 1'b1; load2 = 1'b1; equal = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (a !== 4'b0000) begin failures++; $display("FAIL reset_a got=%b exp=0000", a); end
      checks++; if (b !== 4'b0000) begin failures++; $display("FAIL reset_b got=%b exp=0000", b); end
      checks++; if (op !== 4'b0000) begin failures++; $display("FAIL reset_op got=%b exp=0000", op); end
      checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_entry();
      int s0;
      s0 = start_cnt;
      number = 4'b0101;
      @(negedge clk);
      load1 = 1'b0;
      repeat (6) @(negedge clk);   // edges 0..5 have passed
      checks++; if (a !== 4'b0000) begin failures++; $display("FAIL entry_a_early got=%b exp=0000", a); end
      @(negedge clk);              // edge 6
      checks++; if (a !== 4'b0101) begin failures++; $display("FAIL entry_a_edge6 got=%b exp=0101", a); end
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL entry_state_b got=%b exp=01", state); end
      repeat (3) @(negedge clk);
      load1 = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL entry_release got=%b exp=01", state); end
      number = 4'b0011;
      press(2, 10);
      checks++; if (b !== 4'b0011) begin failures++; $display("FAIL entry_b got=%b exp=0011", b); end
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL entry_state_eq got=%b exp=10", state); end
      press(3, 10);
      checks++; if (op !== 4'b0000) begin failures++; $display("FAIL entry_op got=%b exp=0000", op); end
      checks++; if (state !== 2'b11) begin failures++; $display("FAIL entry_state_done got=%b exp=11", state); end
      checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL entry_start_cnt got=%0d exp=1", start_cnt - s0); end
   endtask

   task automatic test_live_op();
      int s0;
      s0 = start_cnt;
      @(negedge clk);
      mux4 = 1'b1;
      repeat (2) @(negedge clk);   // edges 0,1
      checks++; if (op !== 4'b0000 || start !== 1'b0) begin failures++; $display("FAIL live_early op=%b start=%b exp op=0000 start=0", op, start); end
      @(negedge clk);              // edge 2
      checks++; if (op !== 4'b0001 || start !== 1'b1) begin failures++; $display("FAIL live_edge3 op=%b start=%b exp op=0001 start=1", op, start); end
      repeat (4) @(negedge clk);
      mux3 = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (op !== 4'b0011) begin failures++; $display("FAIL live_op2 got=%b exp=0011", op); end
      checks++; if (start_cnt - s0 !== 2) begin failures++; $display("FAIL live_start_cnt got=%0d exp=2", start_cnt - s0); end
      checks++; if (a !== 4'b0101 || b !== 4'b0011) begin failures++; $display("FAIL live_ab a=%b b=%b exp a=0101 b=0011", a, b); end
   endtask

   task automatic test_bounce();
      int s0;
      s0 = start_cnt;
      number = 4'b1001;
      for (int r = 0; r < 5; r++) begin
         @(negedge clk); load1 = 1'b0;
         repeat (3) @(negedge clk); load1 = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      checks++; if (state !== 2'b11 || a !== 4'b0101) begin failures++; $display("FAIL bounce_reject state=%b a=%b exp state=11 a=0101", state, a); end
      checks++; if (start_cnt - s0 !== 0) begin failures++; $display("FAIL bounce_start got=%0d exp=0", start_cnt - s0); end
      press(1, 4);
      checks++; if (state !== 2'b01 || a !== 4'b1001) begin failures++; $display("FAIL bounce_accept state=%b a=%b exp state=01 a=1001", state, a); end
      checks++; if (b !== 4'b0011) begin failures++; $display("FAIL bounce_b got=%b exp=0011", b); end
   endtask

   task automatic test_order_priority();
      int s0;
      test_reset();
      s0 = start_cnt;
      number = 4'b1110;
      press(3, 8);
      press(2, 8);
      checks++; if (state !== 2'b00 || a !== 4'b0000 || b !== 4'b0000) begin failures++; $display("FAIL order_wait_a state=%b a=%b b=%b exp 00/0000/0000", state, a, b); end
      checks++; if (start_cnt - s0 !== 0) begin failures++; $display("FAIL order_start got=%0d exp=0", start_cnt - s0); end
      number = 4'b0110; press(1, 8);
      number = 4'b1100; press(2, 8);
      checks++; if (state !== 2'b10 || a !== 4'b0110 || b !== 4'b1100) begin failures++; $display("FAIL order_setup state=%b a=%b b=%b exp 10/0110/1100", state, a, b); end
      number = 4'b0111;
      @(negedge clk); load1 = 1'b0; load2 = 1'b0;
      repeat (8) @(negedge clk);
      load1 = 1'b1; load2 = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (a !== 4'b0111 || b !== 4'b1100) begin failures++; $display("FAIL order_prio a=%b b=%b exp a=0111 b=1100", a, b); end
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL order_prio_state got=%b exp=10", state); end
      press(3, 8);
      checks++; if (state !== 2'b11 || op !== 4'b0011) begin failures++; $display("FAIL order_done state=%b op=%b exp state=11 op=0011", state, op); end
      number = 4'b1111;
      press(1, 8);
      checks++; if (state !== 2'b01 || a !== 4'b1111 || b !== 4'b1100) begin failures++; $display("FAIL order_reload state=%b a=%b b=%b exp 01/1111/1100", state, a, b); end
   endtask

   task automatic test_reset_mid_debounce();
      number = 4'b0101;
      @(negedge clk); load2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (state !== 2'b00 || a !== 4'b0000 || b !== 4'b0000) begin failures++; $display("FAIL arst_now state=%b a=%b b=%b exp 00/0000/0000", state, a, b); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (state !== 2'b00 || b !== 4'b0000) begin failures++; $display("FAIL arst_held_ignored state=%b b=%b exp 00/0000", state, b); end
      number = 4'b0110;
      press(1, 8);
      repeat (10) @(negedge clk);
      checks++; if (state !== 2'b01 || a !== 4'b0110 || b !== 4'b0000) begin failures++; $display("FAIL arst_single_press state=%b a=%b b=%b exp 01/0110/0000", state, a, b); end
      load2 = 1'b1;
      repeat (10) @(negedge clk);
      number = 4'b1010;
      press(2, 8);
      checks++; if (state !== 2'b10 || b !== 4'b1010) begin failures++; $display("FAIL arst_repress state=%b b=%b exp 10/1010", state, b); end
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_live_op();
      test_bounce();
      test_order_priority();
      test_reset_mid_debounce();
      checks++; if (consec_cnt !== 0) begin failures++; $display("FAIL start_consecutive got=%0d exp=0", consec_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end stage sitting directly upstream of the calculator ALU. It conditions the three active-low push-buttons (load operand 1, load operand 2, equal) and the four operation-select switches. It captures operands A and B from the shared `number` switch bus, and presents registered operands, a registered opcode and a one-cycle `start` strobe to the ALU. A small FSM enforces the A → B → equal entry order and drives a state indicator for board LEDs.

## Interface
- `N`, default 4: operand width; `number`, `a`, `b` are N bits.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a button level change; minimum 2. Use 4 in simulation and about 250000 on the board.

- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `number` in N: operand switches, sampled only on a load event.
- `load1` in 1: active-low button, capture A.
- `load2` in 1: active-low button, capture B.
- `equal` in 1: active-low button, launch computation.
- `mux1`, `mux2`, `mux3`, `mux4` in 1 each: operation-select switches; `op_sel = {mux1,mux2,mux3,mux4}`.
- `a` out N: registered operand A.
- `b` out N: registered operand B.
- `op` out 4: registered opcode passed to the ALU.
- `start` out 1: one-cycle strobe telling the ALU that `a`/`b`/`op` hold a new request.
- `state` out 2: FSM state code for LEDs.

## Operation
- **Button conditioning**, identical per button:
  - 2-FF synchronizer, then a debounce counter (width `$clog2(DEBOUNCE_CYCLES)+1`).
  - The counter clears whenever the synchronized value equals the debounced level.
  - The counter increments while they differ.
  - On the cycle the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A 1→0 flip of the debounced level produces a registered one-cycle press pulse. A 0→1 flip (release) produces nothing.
- **Simultaneous press pulses** in one cycle resolve by priority load1 > load2 > equal. Only the winner acts and the losers are discarded.
- **FSM states:**
  - `WAIT_A` = 2'b00
    - load1: `a` ← `number` → `WAIT_B`.
    - load2 and equal: ignored.
  - `WAIT_B` = 2'b01
    - load2: `b` ← `number` → `WAIT_EQ`.
    - load1: reload `a`, stay.
    - equal: ignored.
  - `WAIT_EQ` = 2'b10
    - equal: `op` ← `op_sel`, `start` = 1 next cycle → `DONE`.
    - load1: reload `a`, stay.
    - load2: reload `b`, stay.
  - `DONE` = 2'b11
    - `op` tracks `op_sel` every cycle. Any cycle where the registered `op_sel` differs from `op` updates `op` and pulses `start`, so the ALU recomputes live as switches move.
    - load1: `a` ← `number` → `WAIT_B`.
    - load2: `b` ← `number`, `start` pulse, stay.
    - equal: `start` pulse, stay.
- `op_sel` passes through a 2-FF synchronizer before use. No debounce is applied.
- `a` and `b` change only on their load events and never otherwise.

## Timing
- **Reset values:** `a` = 0, `b` = 0, `op` = 0, `start` = 0, `state` = `WAIT_A`. Debounced levels = 1 (released), counters = 0, synchronizers = 1.
- **Reset mid-debounce or mid-FSM:** everything returns to the reset values immediately. A button still held low after reset deasserts is debounced afresh and produces exactly one press.
- **Press latency:** with the first edge sampling a button low counted as edge 0, the debounced flip occurs at edge `DEBOUNCE_CYCLES`+1. The press pulse is high in the following cycle. The FSM register update (`a`, `b`, `op`, `state`) occurs at edge `DEBOUNCE_CYCLES`+2.
- **`start` timing:** `start` is high for exactly the one cycle after the FSM update edge and is never high for two consecutive cycles.
- **`op_sel` latency:** `op_sel` change to `op` update in `DONE` takes 3 edges (2 sync + 1 register). `start` rises in the same cycle that the new `op` appears.
- **Glitch rejection:** a low glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no pulse.
- **Held buttons:** a button held indefinitely yields one press only.

## Test plan
1. **Reset:** `rst` = 1 for 3 cycles with all buttons high → `a` = 0, `b` = 0, `op` = 0, `start` = 0, `state` = 00.
2. **Basic entry**, `DEBOUNCE_CYCLES` = 4:
   - `number` = 0101, load1 low 10 cycles → `a` = 0101 exactly 6 edges after the first low sample, `state` = 01.
   - `number` = 0011, load2 → `b` = 0011, `state` = 10.
   - `op_sel` = 0000, equal → `op` = 0000, single `start` pulse, `state` = 11.
3. **Live op change in `DONE`:** `mux4` 0→1 → `op` = 0001 and one `start` pulse 3 edges later. `mux3` = 1 → `op` = 0011 and another single pulse. `a`/`b` remain unchanged.
4. **Bounce rejection:** load1 low for 3 cycles then high, repeated 5 times → no state change and no `start`. A 4-cycle low is accepted.
5. **Order and priority:**
   - In `WAIT_A`, pressing equal and load2 → ignored.
   - load1 and load2 pulses landing in the same cycle in `WAIT_EQ` → only `a` reloads.
   - load1 in `DONE` → `state` = 01, `b` retained.
6. **Async reset mid-debounce:** assert `rst` while load2 is counting → no `b` update. Deassert with load2 still held → one press, `b` ← `number` only if `state` was advanced to `WAIT_B` first, otherwise ignored.
